// File: rtl/mips_mem_pkg.sv
// Shared defaults and FSM state encoding for the load/store path.
package mips_mem_pkg;

  localparam int AWIDTH_DEF = 8;
  localparam int DWIDTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    FWD   = 2'd3
  } lsu_state_t;

endpackage

// File: rtl/store_buffer.sv
// Circular store buffer with a youngest-match lookup over all valid entries,
// including the head entry that may be popping this cycle.
module store_buffer
  import mips_mem_pkg::*;
#(
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int SBDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [AWIDTH-1:0] push_addr,
  input  logic [DWIDTH-1:0] push_data,
  input  logic              pop,
  output logic [AWIDTH-1:0] head_addr,
  output logic [DWIDTH-1:0] head_data,
  output logic              empty,
  output logic              full,
  input  logic [AWIDTH-1:0] lookup_addr,
  output logic              hit,
  output logic [DWIDTH-1:0] hit_data
);

  localparam int PW = $clog2(SBDEPTH);

  logic [AWIDTH-1:0] addr_q [SBDEPTH];
  logic [DWIDTH-1:0] data_q [SBDEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign empty     = (count == '0);
  assign full      = (count == (PW+1)'(SBDEPTH));
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;
  assign head_addr = addr_q[rd_ptr];
  assign head_data = data_q[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_q[wr_ptr] <= push_addr;
      data_q[wr_ptr] <= push_data;
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest store.
  always_comb begin
    logic [PW-1:0] idx;
    idx      = '0;
    hit      = 1'b0;
    hit_data = '0;
    for (int unsigned i = 0; i < SBDEPTH; i++) begin
      idx = rd_ptr + PW'(i);
      if (((PW+1)'(i) < count) && (addr_q[idx] == lookup_addr)) begin
        hit      = 1'b1;
        hit_data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: buffers stores, forwards loads that hit the buffer and
// issues misses to a registered-read RAM, draining stores when the read port is idle.
module load_store_unit
  import mips_mem_pkg::*;
#(
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int SBDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [DWIDTH-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DWIDTH-1:0] rsp_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_raddr,
  output logic [AWIDTH-1:0] mem_waddr,
  output logic [DWIDTH-1:0] mem_wdata,
  input  logic [DWIDTH-1:0] mem_rdata
);

  lsu_state_t        state;
  logic [AWIDTH-1:0] cap_addr;
  logic [DWIDTH-1:0] cap_data;
  logic [DWIDTH-1:0] rsp_q;
  logic              accept;
  logic              sb_empty;
  logic              sb_full;
  logic              sb_hit;
  logic [DWIDTH-1:0] sb_hit_data;

  assign req_ready = (state == IDLE) && !sb_full;
  assign accept    = req_valid && req_ready;
  assign mem_rd    = (state == ISSUE);
  assign mem_wr    = (state != ISSUE) && !sb_empty;
  assign mem_raddr = cap_addr;
  assign rsp_valid = (state == WAIT) || (state == FWD);

  store_buffer #(
    .AWIDTH (AWIDTH),
    .DWIDTH (DWIDTH),
    .SBDEPTH(SBDEPTH)
  ) u_sb (
    .clk        (clk),
    .rst        (rst),
    .push       (accept && req_we),
    .push_addr  (req_addr),
    .push_data  (req_wdata),
    .pop        (mem_wr),
    .head_addr  (mem_waddr),
    .head_data  (mem_wdata),
    .empty      (sb_empty),
    .full       (sb_full),
    .lookup_addr(req_addr),
    .hit        (sb_hit),
    .hit_data   (sb_hit_data)
  );

  // RAM read data is only valid during WAIT, so it is passed straight through
  // then and latched into rsp_q so the output holds afterwards.
  always_comb begin
    rsp_data = rsp_q;
    if (state == WAIT)     rsp_data = mem_rdata;
    else if (state == FWD) rsp_data = cap_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cap_addr <= '0;
      cap_data <= '0;
      rsp_q    <= '1;
    end else begin
      case (state)
        IDLE: begin
          if (accept && !req_we) begin
            cap_addr <= req_addr;
            if (sb_hit) begin
              cap_data <= sb_hit_data;
              state    <= FWD;
            end else begin
              state <= ISSUE;
            end
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          rsp_q <= mem_rdata;
          state <= IDLE;
        end
        FWD: begin
          rsp_q <= cap_data;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
